// File: rtl/p2p_rx_pkt_fifo_if.sv
// AXI4-Stream bundle (512-bit data) shared by the CMAC receive side and the packet output.
// The receive side cannot be back-pressured, so its sink modport has no tready.
interface p2p_rx_pkt_fifo_if #(
  parameter int DW = 512
);
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tuser_err;

  modport master (output tvalid, tdata, tkeep, tlast, tuser_err, input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tlast, tuser_err, output tready);
  modport sink   (input  tvalid, tdata, tkeep, tlast, tuser_err);
endinterface

// File: rtl/p2p_rx_pkt_fifo.sv
// Store-and-forward packet FIFO for the 322 MHz CMAC domain: buffers a non-stallable
// stream and releases only complete, error-free packets onto a ready/valid master.
module p2p_rx_pkt_fifo #(
  parameter int DEPTH    = 64,
  parameter bit DROP_ERR = 1'b1
) (
  input  logic                     cmac_clk,
  input  logic                     cmac_rst,
  p2p_rx_pkt_fifo_if.sink          s_axis,
  p2p_rx_pkt_fifo_if.master        m_axis,
  output logic [31:0]              stat_pkt_fwd,
  output logic [31:0]              stat_pkt_drop_ovf,
  output logic [31:0]              stat_pkt_drop_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         err;
  } beat_t;

  typedef enum logic {WR_PASS, WR_DROP} wr_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  wr_state_e   state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [31:0] fwd_q, fwd_d, ovf_q, ovf_d, err_q, err_d;
  logic        r_valid_q, r_valid_d;
  logic        m_valid_q, m_valid_d;
  beat_t       r_beat_q;
  beat_t       m_beat_q, m_beat_d;
  beat_t       mem [DEPTH];

  logic [PW-1:0] used;
  logic          full;
  logic          mem_we;
  logic          rd_en;
  logic          out_load;
  logic          out_hs;
  beat_t         w_beat;

  // Occupancy runs from rd_ptr (advanced on the output handshake), so beats held in the
  // read pipeline still own their RAM slot and the buffer holds exactly DEPTH beats.
  assign used   = wr_ptr_q - rd_ptr_q;
  assign full   = (used == PW'(DEPTH));
  assign w_beat = '{data: s_axis.tdata, keep: s_axis.tkeep, last: s_axis.tlast,
                    err:  s_axis.tlast & s_axis.tuser_err};

  // NOTE: every signal assigned in an always_comb gets a default at the top; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    fwd_d        = fwd_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    if (s_axis.tvalid) begin
      unique case (state_q)
        WR_PASS: begin
          if (full) begin
            wr_ptr_d = commit_ptr_q;
            if (s_axis.tlast) ovf_d   = sat_inc(ovf_q);
            else              state_d = WR_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis.tlast) begin
              if (DROP_ERR && s_axis.tuser_err) begin
                wr_ptr_d = commit_ptr_q;
                err_d    = sat_inc(err_q);
              end else begin
                commit_ptr_d = wr_ptr_q + PW'(1);
                fwd_d        = sat_inc(fwd_q);
              end
            end
          end
        end
        WR_DROP: begin
          if (s_axis.tlast) begin
            ovf_d   = sat_inc(ovf_q);
            state_d = WR_PASS;
          end
        end
        default: state_d = WR_PASS;
      endcase
    end
  end

  // Two-stage read: RAM data register, then the output register the master drives.
  always_comb begin
    out_hs      = m_valid_q & m_axis.tready;
    out_load    = r_valid_q & (~m_valid_q | m_axis.tready);
    rd_en       = (fetch_ptr_q != commit_ptr_q) & (~r_valid_q | out_load);
    fetch_ptr_d = fetch_ptr_q + PW'(rd_en);
    rd_ptr_d    = rd_ptr_q + PW'(out_hs);
    r_valid_d   = rd_en | (r_valid_q & ~out_load);
    m_valid_d   = out_load | (m_valid_q & ~m_axis.tready);
    m_beat_d    = m_beat_q;
    if (out_load) begin
      m_beat_d     = r_beat_q;
      m_beat_d.err = DROP_ERR ? 1'b0 : r_beat_q.err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge cmac_clk) begin
    if (cmac_rst) begin
      state_q      <= WR_PASS;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      fwd_q        <= '0;
      ovf_q        <= '0;
      err_q        <= '0;
      r_valid_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_beat_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      fwd_q        <= fwd_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      r_valid_q    <= r_valid_d;
      m_valid_q    <= m_valid_d;
      m_beat_q     <= m_beat_d;
    end
  end

  // NOTE: the RAM and its read register carry no reset; pointers and valid flags gate
  // every use, so stale contents are never observed and the array maps onto block RAM.
  always_ff @(posedge cmac_clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= w_beat;
    if (rd_en)  r_beat_q <= mem[fetch_ptr_q[AW-1:0]];
  end

  assign m_axis.tvalid     = m_valid_q;
  assign m_axis.tdata      = m_beat_q.data;
  assign m_axis.tkeep      = m_beat_q.keep;
  assign m_axis.tlast      = m_beat_q.last;
  assign m_axis.tuser_err  = m_beat_q.err;
  assign stat_pkt_fwd      = fwd_q;
  assign stat_pkt_drop_ovf = ovf_q;
  assign stat_pkt_drop_err = err_q;
  assign fifo_level        = commit_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_p2p_rx_pkt_fifo.sv
// Bench for p2p_rx_pkt_fifo: a packet-level occupancy model and scoreboard checked every
// cycle, plus literal expectations for latency, counters and the overflow scenarios.
module tb_p2p_rx_pkt_fifo;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         err;
  } beat_t;

  logic        cmac_clk = 1'b0;
  logic        cmac_rst;
  logic [31:0] stat_fwd, stat_ovf, stat_err;
  logic [6:0]  level;

  p2p_rx_pkt_fifo_if s_if ();
  p2p_rx_pkt_fifo_if m_if ();

  p2p_rx_pkt_fifo #(.DEPTH(DEPTH), .DROP_ERR(1'b1)) dut (
    .cmac_clk          (cmac_clk),
    .cmac_rst          (cmac_rst),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .stat_pkt_fwd      (stat_fwd),
    .stat_pkt_drop_ovf (stat_ovf),
    .stat_pkt_drop_err (stat_err),
    .fifo_level        (level)
  );

  always #2 cmac_clk = ~cmac_clk;

  // Model state: committed beats awaiting output, the packet being received, and counters.
  beat_t exp_q[$];
  beat_t cur_pkt[$];
  bit    drop_mode;
  int    m_fwd, m_ovf, m_err, beats_out;
  int    tests, fails;

  // Stimulus registers applied to the pins by tick().
  bit           in_valid, in_last, in_err, tready_v, rst_v, ready_rand;
  logic [511:0] in_data;
  logic [63:0]  in_keep;
  bit           prev_stall;
  beat_t        held;

  task automatic check(input string name, input logic [577:0] act, input logic [577:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic beat_t out_beat();
    return {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser_err};
  endfunction

  // Drives one cycle at the falling edge, advances the model across the next rising edge,
  // then checks registered outputs at the following falling edge.
  task automatic tick();
    beat_t ob, e, ib;
    int    free;
    if (ready_rand) tready_v = ($urandom_range(0, 1) == 1);
    cmac_rst       = rst_v;
    s_if.tvalid    = in_valid;
    s_if.tdata     = in_data;
    s_if.tkeep     = in_keep;
    s_if.tlast     = in_last;
    s_if.tuser_err = in_err;
    m_if.tready    = tready_v;
    ob = out_beat();
    if (rst_v) begin
      exp_q.delete();
      cur_pkt.delete();
      drop_mode  = 1'b0;
      m_fwd      = 0;
      m_ovf      = 0;
      m_err      = 0;
      prev_stall = 1'b0;
    end else begin
      free = DEPTH - exp_q.size() - cur_pkt.size();
      if (m_if.tvalid && tready_v) begin
        if (exp_q.size() == 0) check("unexpected_beat_valid", m_if.tvalid, 0);
        else begin
          e = exp_q.pop_front();
          check("out_beat", ob, e);
          beats_out++;
        end
      end
      if (in_valid) begin
        ib = '{data: in_data, keep: in_keep, last: in_last, err: 1'b0};
        if (drop_mode) begin
          if (in_last) begin m_ovf++; drop_mode = 1'b0; end
        end else if (free == 0) begin
          cur_pkt.delete();
          if (in_last) m_ovf++;
          else         drop_mode = 1'b1;
        end else begin
          cur_pkt.push_back(ib);
          if (in_last) begin
            if (in_err) m_err++;
            else begin
              foreach (cur_pkt[i]) exp_q.push_back(cur_pkt[i]);
              m_fwd++;
            end
            cur_pkt.delete();
          end
        end
      end
      prev_stall = m_if.tvalid && !tready_v;
      held       = ob;
    end
    @(negedge cmac_clk);
    check("fifo_level", level, exp_q.size());
    check("stat_fwd", stat_fwd, m_fwd);
    check("stat_ovf", stat_ovf, m_ovf);
    check("stat_err", stat_err, m_err);
    if (prev_stall) begin
      check("stall_tvalid", m_if.tvalid, 1);
      check("stall_payload", out_beat(), held);
    end
  endtask

  task automatic send_beats(input int len, input int n_send, input bit err_last);
    for (int i = 0; i < n_send; i++) begin
      in_valid = 1'b1;
      in_data  = {16{$urandom()}};
      in_keep  = {$urandom(), $urandom()};
      in_last  = (i == len - 1);
      in_err   = in_last ? err_last : ($urandom_range(0, 1) == 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit err_last);
    send_beats(len, len, err_last);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int n;
    n          = 0;
    ready_rand = 1'b0;
    tready_v   = 1'b1;
    in_valid   = 1'b0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) fail_now("drain_timeout");
    idle(2);
  endtask

  task automatic measure_latency(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (!m_if.tvalid && n < 8) begin
      tick();
      n++;
    end
    check(name, n, 2);
  endtask

  initial begin
    int snap;
    tests = 0; fails = 0; beats_out = 0;
    in_valid = 0; in_last = 0; in_err = 0; in_data = '0; in_keep = '0;
    tready_v = 1; ready_rand = 0; rst_v = 1; s_if.tready = 1'b1;
    @(negedge cmac_clk);
    repeat (3) tick();
    rst_v = 0;
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tdata", m_if.tdata, 0);
    check("rst_level", level, 0);
    check("rst_fwd", stat_fwd, 0);
    idle(2);

    // T1: 1, 4 and 16 beat packets with the output idle; two-cycle commit-to-valid latency.
    send_pkt(1, 0);  measure_latency("lat_1beat");  drain();
    send_pkt(4, 0);  measure_latency("lat_4beat");  drain();
    send_pkt(16, 0); measure_latency("lat_16beat"); drain();
    check("t1_fwd", stat_fwd, 3);

    // T2: errored packet is discarded, the next good one passes.
    send_pkt(4, 1);
    idle(4);
    check("t2_tvalid", m_if.tvalid, 0);
    check("t2_err", stat_err, 1);
    check("t2_level", level, 0);
    send_pkt(3, 0); drain();
    check("t2_fwd", stat_fwd, 4);

    // T3: stalled output; four 16-beat packets fill the buffer, the fifth overflows.
    tready_v = 0;
    for (int p = 0; p < 5; p++) send_pkt(16, 0);
    idle(2);
    check("t3_level", level, 64);
    check("t3_ovf", stat_ovf, 1);
    check("t3_fwd", stat_fwd, 8);
    snap = beats_out;
    drain();
    check("t3_beats_out", beats_out - snap, 64);

    // T4: a packet longer than the buffer always overflows.
    send_pkt(70, 0);
    check("t4_ovf", stat_ovf, 2);
    send_pkt(2, 0); drain();
    check("t4_fwd", stat_fwd, 9);

    // T5: random lengths, back to back, random occasional error, 50% tready.
    ready_rand = 1;
    for (int p = 0; p < 200; p++) send_pkt($urandom_range(1, 8), ($urandom_range(0, 9) == 0));
    drain();
    check("t5_queue_empty", level, 0);

    // T6: reset with a packet waiting at the output and another half received.
    tready_v = 0;
    send_pkt(3, 0);
    idle(3);
    check("t6_pre_tvalid", m_if.tvalid, 1);
    send_beats(4, 2, 0);
    rst_v = 1; tick(); rst_v = 0;
    check("t6_tvalid", m_if.tvalid, 0);
    check("t6_tdata", m_if.tdata, 0);
    check("t6_tkeep", m_if.tkeep, 0);
    check("t6_tlast", m_if.tlast, 0);
    check("t6_level", level, 0);
    check("t6_fwd", stat_fwd, 0);
    idle(2);
    tready_v = 1;
    send_pkt(3, 0); drain();
    check("t6_after_fwd", stat_fwd, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
